// File: rtl/uart_rx_os16.sv
// uart_rx_os16: UART receiver with 16x oversampling and a 3-sample majority vote per bit.
// It rejects false starts and reports framing errors and overruns.
// Received bytes are held on a valid/ready interface, one byte at a time.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing. Without it the framing is 8N1.
module uart_rx_os16 #(
   parameter int clk_freq  = 1000000,
   parameter int baud_rate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);

   localparam int DIV = clk_freq / (baud_rate * 16);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_next;
   logic            rx_meta, rxs, rxs_prev;
   logic            armed;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [3:0]      s;
   logic [1:0]      samp;
   logic            maj;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            start_det, decide, boundary, load;
   logic            par_err_calc;
`ifdef UART_RX_PARITY_EN
   logic            par_bit;
`endif

   // Samples are captured on the ticks that advance s into slots 7, 8 and 9.
   // The third sample is the live rxs on the decision tick, so the bit is decided as s becomes 9.
   assign tick      = (tick_cnt == TICK_LAST);
   assign decide    = tick && (s == 4'd8);
   assign boundary  = tick && (s == 4'd15);
   assign start_det = (state == IDLE) && armed && rxs_prev && !rxs;
   assign maj       = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
   assign load      = (state == STOP) && decide;
   assign busy      = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_err_calc = (^shift) ^ par_bit;
`else
   assign par_err_calc = 1'b0;
`endif

   // Two-flop synchronizer on the async line, plus a delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rx;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   // Re-arm start detection only once the line has been seen high in IDLE, so a held break cannot retrigger
   always_ff @(posedge clk) begin
      if (rst)
         armed <= 1'b0;
      else if (state != IDLE)
         armed <= 1'b0;
      else if (rxs)
         armed <= 1'b1;
   end

   // Oversampling tick divider and 16-slot sample counter, both phase-aligned to the start edge
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         s        <= 4'd0;
      end else if (start_det) begin
         tick_cnt <= '0;
         s        <= 4'd0;
      end else if (state != IDLE) begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick)
            s <= s + 4'd1;
      end
   end

   // Mid-bit sample capture, data shift register (LSB first), bit counter and parity bit
   always_ff @(posedge clk) begin
      if (rst) begin
         samp    <= 2'b00;
         bit_cnt <= 3'd0;
         shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         if (tick && s == 4'd6)
            samp[0] <= rxs;
         if (tick && s == 4'd7)
            samp[1] <= rxs;
         if (start_det)
            bit_cnt <= 3'd0;
         if (state == DATA && decide)
            shift <= {maj, shift[7:1]};
         if (state == DATA && boundary)
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
         if (state == PARITY && decide)
            par_bit <= maj;
`endif
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // FSM next-state logic: the stop bit is decided mid-bit so IDLE is re-entered early
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start_det) state_next = START;
         START: begin
            if (decide && maj)
               state_next = IDLE;
            else if (boundary)
               state_next = DATA;
         end
         DATA: begin
            if (boundary && bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (boundary) state_next = STOP;
`endif
         STOP:  if (decide) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output holding register: a new byte always wins, and overrun flags a byte that was never accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            rx_data    <= shift;
            rx_valid   <= 1'b1;
            frame_err  <= ~maj;
            parity_err <= par_err_calc;
            overrun    <= rx_valid && !rx_ready;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
